// File: rtl/comet2_wait_ram.sv
// ---------------------------------------------------------------------------
// comet2_wait_ram : req/ready word RAM with wait states, write protect, errors
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module comet2_wait_ram #(
  parameter int          ADDR_W    = 8,
  parameter int          DATA_W    = 16,
  parameter int          RD_WAIT   = 0,
  parameter int          WR_WAIT   = 0,
  parameter string       INIT_FILE = "",
  parameter bit          PROT_EN   = 1'b0,
  parameter logic [15:0] PROT_LO   = 16'h0000,
  parameter logic [15:0] PROT_HI   = 16'h004F
) (
  input  logic              mclk,
  input  logic              n_rst,
  input  logic              req,
  input  logic              we,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              busy,
  output logic              err,
  output logic [15:0]       err_addr,
  input  logic              err_clr
);

  localparam int          DEPTH       = 1 << ADDR_W;
  localparam logic [1:0]  S_IDLE      = 2'd0;
  localparam logic [1:0]  S_WAIT      = 2'd1;
  localparam logic [1:0]  S_DONE      = 2'd2;
  localparam logic [3:0]  C_RD_WAIT   = 4'(RD_WAIT);
  localparam logic [3:0]  C_WR_WAIT   = 4'(WR_WAIT);
  localparam logic [15:0] C_PROT_SPAN = PROT_HI - PROT_LO;

  logic [1:0]        state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic [15:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       err_addr_q, err_addr_d;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];

  logic              w_acc_we;
  logic [15:0]       w_acc_addr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic [3:0]        w_load_cnt;
  logic              w_access;
  logic              w_oor;
  logic              w_prot;
  logic              w_fault;
  logic              w_wr_en;
  logic [15:0]       w_prot_off;
  logic [ADDR_W-1:0] w_idx;

  // Zero-wait accesses complete from IDLE, so they must see the live inputs.
  always_comb begin
    w_acc_we    = we_q;
    w_acc_addr  = addr_q;
    w_acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      w_acc_we    = we;
      w_acc_addr  = addr;
      w_acc_wdata = wdata;
    end
  end

  generate
    if (ADDR_W < 16) begin : g_oor
      assign w_oor = |w_acc_addr[15:ADDR_W];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  // Offset compare keeps the window test free of constant-bound comparisons.
  assign w_prot_off = w_acc_addr - PROT_LO;
  assign w_prot     = PROT_EN && w_acc_we && (w_prot_off <= C_PROT_SPAN);
  assign w_load_cnt = we ? C_WR_WAIT : C_RD_WAIT;
  assign w_access   = ((state_q == S_IDLE) && req && (w_load_cnt == 4'd0)) ||
                      ((state_q == S_WAIT) && (wcnt_q == 4'd1));
  assign w_fault    = w_access && (w_oor || w_prot);
  assign w_wr_en    = w_access && w_acc_we && !w_oor && !w_prot;
  assign w_idx      = w_acc_addr[ADDR_W-1:0];

  always_ff @(posedge mclk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          wcnt_d  = w_load_cnt;
          state_d = (w_load_cnt != 4'd0) ? S_WAIT : S_DONE;
        end
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (w_access && !w_acc_we) rdata_d = w_oor ? '0 : mem_q[w_idx];
    // A fault on the same edge as err_clr keeps the flag set.
    err_d = w_fault ? 1'b1 : (err_clr ? 1'b0 : err_q);
    if (w_fault) err_addr_d = w_acc_addr;
  end

  always_comb begin
    ready = (state_q == S_DONE);
    busy  = (state_q != S_IDLE);
  end

  assign rdata    = rdata_q;
  assign err      = err_q;
  assign err_addr = err_addr_q;

  // Array has no reset; contents are established once at time zero.
  always @(posedge mclk) begin
    if (w_wr_en) mem_q[w_idx] <= w_acc_wdata;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] = '0;
  end

endmodule

`default_nettype wire
